mod3_counter: RTL and testbench

MOD3_COUNTER -- requirements
Module: mod3_counter

---
 rtl/mod3_pkg.sv | 14 +
 rtl/mod3_counter_if.sv | 49 ++++
 rtl/mod3_succ.sv | 11 +
 rtl/mod3_counter.sv | 55 +++++
 tb/tb_mod3_counter.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/mod3_pkg.sv
// Shared mod-3 types, constants and the successor function used by every
// lookup in the counter.
package mod3_pkg;

  typedef logic [1:0] mod3_idx_t;

  localparam mod3_idx_t MOD3_MAX = 2'd2;

  // Out-of-range index 3 folds to 0, the same result as stepping from MOD3_MAX.
  function automatic mod3_idx_t mod3_next(input mod3_idx_t val);
    return (val >= MOD3_MAX) ? 2'd0 : val + 2'd1;
  endfunction

endpackage

// File: rtl/mod3_counter_if.sv
// Signal bundle between the mod-3 counter and its user.
// Optional feature macro: MOD3_COUNTER_ILLEGAL_CHECK_EN adds the illegal flag.
interface mod3_counter_if;
  import mod3_pkg::*;

  mod3_idx_t num;
  mod3_idx_t mod3num;
  logic      advance;
  logic      load;
  mod3_idx_t load_value;
  mod3_idx_t count;
  mod3_idx_t count_next;
  mod3_idx_t count_last;
  logic      wrap;
`ifdef MOD3_COUNTER_ILLEGAL_CHECK_EN
  logic      illegal;
`endif

  modport master (
    output num,
    output advance,
    output load,
    output load_value,
    input  mod3num,
    input  count,
    input  count_next,
    input  count_last,
    input  wrap
`ifdef MOD3_COUNTER_ILLEGAL_CHECK_EN
    , input illegal
`endif
  );

  modport slave (
    input  num,
    input  advance,
    input  load,
    input  load_value,
    output mod3num,
    output count,
    output count_next,
    output count_last,
    output wrap
`ifdef MOD3_COUNTER_ILLEGAL_CHECK_EN
    , output illegal
`endif
  );

endinterface

// File: rtl/mod3_succ.sv
// Combinational mod-3 successor: 0->1, 1->2, 2->0, 3->0.
module mod3_succ
  import mod3_pkg::*;
(
  input  mod3_idx_t val_i,
  output mod3_idx_t succ_o
);

  assign succ_o = mod3_next(val_i);

endmodule

// File: rtl/mod3_counter.sv
// Mod-3 rotating priority pointer with load, advance and a wrap pulse.
// Optional feature macro: MOD3_COUNTER_ILLEGAL_CHECK_EN adds the illegal flag.
module mod3_counter
  import mod3_pkg::*;
#(
  parameter mod3_idx_t RESET_VALUE = 2'd0
) (
  input  logic          clock,
  input  logic          reset,
  mod3_counter_if.slave bus
);

  mod3_idx_t count_q, count_d;
  logic      wrap_q, wrap_d;
  mod3_idx_t count_next;
  mod3_idx_t count_last;
  mod3_idx_t mod3num;

  mod3_succ u_succ_num  (.val_i(bus.num),    .succ_o(mod3num));
  mod3_succ u_succ_cnt  (.val_i(count_q),    .succ_o(count_next));
  mod3_succ u_succ_next (.val_i(count_next), .succ_o(count_last));

  // Load wins over advance; only an advance out of MOD3_MAX raises wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_value > MOD3_MAX) ? 2'd0 : bus.load_value;
    end else if (bus.advance) begin
      count_d = count_next;
      wrap_d  = (count_q == MOD3_MAX);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.mod3num    = mod3num;
  assign bus.count      = count_q;
  assign bus.count_next = count_next;
  assign bus.count_last = count_last;
  assign bus.wrap       = wrap_q;

`ifdef MOD3_COUNTER_ILLEGAL_CHECK_EN
  assign bus.illegal = (bus.num == 2'd3) || (bus.load && (bus.load_value == 2'd3));
`endif

endmodule

// File: tb/tb_mod3_counter.sv
// Directed bench for mod3_counter: one instance with RESET_VALUE=0, one with 1.
// Optional feature macro: MOD3_COUNTER_ILLEGAL_CHECK_EN enables illegal checks.
module tb_mod3_counter;

  logic clock;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  mod3_counter_if bus_a ();
  mod3_counter_if bus_b ();

  mod3_counter #(.RESET_VALUE(2'd0)) u_dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
  mod3_counter #(.RESET_VALUE(2'd1)) u_dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] nm, input logic adv,
                       input logic ld, input logic [1:0] lv);
    reset = rst;
    bus_a.num = nm; bus_a.advance = adv; bus_a.load = ld; bus_a.load_value = lv;
    bus_b.num = nm; bus_b.advance = adv; bus_b.load = ld; bus_b.load_value = lv;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] exp_mod3 [4];
  logic [1:0] exp_cnt_a [4];
  logic [1:0] exp_cnt_b [4];
  logic       exp_wrp_a [4];
  logic       exp_wrp_b [4];

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    exp_mod3  = '{2'd1, 2'd2, 2'd0, 2'd0};
    exp_cnt_a = '{2'd1, 2'd2, 2'd0, 2'd1};
    exp_wrp_a = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_cnt_b = '{2'd2, 2'd0, 2'd1, 2'd2};
    exp_wrp_b = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Reset with load and advance both pending: reset must win.
    drive(1'b1, 2'd0, 1'b1, 1'b1, 2'd2);
    tick();
    check("rst_count_a", bus_a.count, 2'd0);
    check("rst_wrap_a",  bus_a.wrap,  1'b0);
    check("rst_count_b", bus_b.count, 2'd1);
    check("rst_wrap_b",  bus_b.wrap,  1'b0);

    // Combinational sweep while reset is still held.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b0, 1'b0, 2'd0);
      check($sformatf("mod3num[%0d]", i), bus_a.mod3num, exp_mod3[i]);
`ifdef MOD3_COUNTER_ILLEGAL_CHECK_EN
      check($sformatf("illegal_num[%0d]", i), bus_a.illegal, (i == 3) ? 1'b1 : 1'b0);
`endif
    end
    check("rst_cnext_b", bus_b.count_next, 2'd2);
    tick();

    // Continuous advance.
    drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    check("adv0_count_a", bus_a.count, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("adv%0d_count_a", i + 1), bus_a.count, exp_cnt_a[i]);
      check($sformatf("adv%0d_wrap_a", i + 1),  bus_a.wrap,  exp_wrp_a[i]);
      check($sformatf("adv%0d_count_b", i + 1), bus_b.count, exp_cnt_b[i]);
      check($sformatf("adv%0d_wrap_b", i + 1),  bus_b.wrap,  exp_wrp_b[i]);
    end
    drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    check("trio_count",      bus_a.count,      2'd1);
    check("trio_count_next", bus_a.count_next, 2'd2);
    check("trio_count_last", bus_a.count_last, 2'd0);

    // Load beats advance (advance from 1 would give 2).
    drive(1'b0, 2'd0, 1'b1, 1'b1, 2'd0);
    tick();
    check("ldpri0_count", bus_a.count, 2'd0);
    check("ldpri0_wrap",  bus_a.wrap,  1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b1, 2'd2);
    tick();
    check("ldpri2_count", bus_a.count, 2'd2);
    check("ldpri2_wrap",  bus_a.wrap,  1'b0);

    // Load of value 3 folds to 0 and must not pulse wrap.
    drive(1'b0, 2'd0, 1'b0, 1'b1, 2'd3);
`ifdef MOD3_COUNTER_ILLEGAL_CHECK_EN
    check("illegal_lv3", bus_a.illegal, 1'b1);
`endif
    tick();
    check("ld3_count", bus_a.count, 2'd0);
    check("ld3_wrap",  bus_a.wrap,  1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd3);
`ifdef MOD3_COUNTER_ILLEGAL_CHECK_EN
    check("illegal_noload", bus_a.illegal, 1'b0);
`endif

    // Hold.
    drive(1'b0, 2'd0, 1'b0, 1'b1, 2'd1);
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    tick();
    tick();
    check("hold_count", bus_a.count, 2'd1);
    check("hold_wrap",  bus_a.wrap,  1'b0);

    // Step to 2, then reset with advance high.
    drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    tick();
    check("pre_rst_count", bus_a.count, 2'd2);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 2'd0);
    tick();
    check("midrst_count_a", bus_a.count, 2'd0);
    check("midrst_wrap_a",  bus_a.wrap,  1'b0);
    check("midrst_count_b", bus_b.count, 2'd1);
    check("midrst_wrap_b",  bus_b.wrap,  1'b0);

    // First post-reset advance steps from RESET_VALUE.
    drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    tick();
    check("post_rst_count_a", bus_a.count, 2'd1);
    check("post_rst_count_b", bus_b.count, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
